// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// mstatus field positions, mtvec modes and the sequencer state encoding.
package trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  // Software-writable mstatus bits (MIE, MPIE); everything else is fixed.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/trap_sequencer_target_calc.sv
// Redirect target computation: trap vector (direct or vectored) or mepc for mret.
module trap_target_calc
  import trap_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_is_trap,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mcause,
  input  logic [XLEN-1:0] i_mepc,
  output logic [XLEN-1:0] o_target
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_offset;
  logic            w_vectored;

  assign w_base     = i_mtvec & ALIGN_MASK;
  // Cause code shifted by 4-byte slots; the top bit falls off, matching a 32-bit truncated sum.
  assign w_offset   = {1'b0, i_mcause[XLEN-2:0]} << 2;
  // Modes 2/3 fall through to direct.
  assign w_vectored = (i_mtvec[1:0] == MTVEC_MODE_VECTORED) && i_mcause[XLEN-1];

  // Select mepc for mret, otherwise the (possibly vectored) trap vector.
  always_comb begin
    o_target = w_base;
    if (!i_is_trap) begin
      o_target = i_mepc;
    end else if (w_vectored) begin
      o_target = w_base + w_offset;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer: accepts traps or mret at instruction
// boundaries, owns mstatus/mepc/mcause/mtval, and hands a redirect PC to the
// core through a valid/ready handshake while holding it with busy.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
  parameter int unsigned XLEN          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            boundary,
  input  logic            trap_pending,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] tval,
  input  logic            mret,
  input  logic [XLEN-1:0] mtvec,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            irq_en,
  output logic [XLEN-1:0] mstatus,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          r_state;
  state_t          w_next_state;
  logic            r_is_trap;
  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_redirect_pc;
  logic [XLEN-1:0] w_target;
  logic            w_trap_acc;
  logic            w_mret_acc;
  logic            w_csr_wr_en;

  trap_target_calc #(
    .XLEN(XLEN)
  ) u_target_calc (
    .i_is_trap (r_is_trap),
    .i_mtvec   (mtvec),
    .i_mcause  (r_mcause),
    .i_mepc    (r_mepc),
    .o_target  (w_target)
  );

  // Next-state decode plus accept/CSR-write qualification; trap beats mret.
  always_comb begin
    w_next_state = r_state;
    w_trap_acc   = 1'b0;
    w_mret_acc   = 1'b0;
    w_csr_wr_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (boundary && trap_pending) begin
          w_trap_acc   = 1'b1;
          w_next_state = SAVE;
        end else if (boundary && mret) begin
          w_mret_acc   = 1'b1;
          w_next_state = SAVE;
        end else begin
          w_csr_wr_en  = csr_we;
        end
      end
      SAVE:     w_next_state = REDIRECT;
      REDIRECT: if (redirect_ready) w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // CSR updates on accept or software write, and target capture in SAVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus     <= RESET_MSTATUS;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
      r_is_trap     <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      if (w_trap_acc) begin
        r_mepc                  <= pc & ALIGN_MASK;
        r_mcause                <= trap_cause;
        r_mtval                 <= tval;
        r_mstatus[MSTATUS_MPIE] <= r_mstatus[MSTATUS_MIE];
        r_mstatus[MSTATUS_MIE]  <= 1'b0;
        r_is_trap               <= 1'b1;
      end else if (w_mret_acc) begin
        r_mstatus[MSTATUS_MIE]  <= r_mstatus[MSTATUS_MPIE];
        r_mstatus[MSTATUS_MPIE] <= 1'b1;
        r_is_trap               <= 1'b0;
      end else if (w_csr_wr_en) begin
        case (csr_addr)
          CSR_MSTATUS: r_mstatus <= (RESET_MSTATUS & ~MSTATUS_WMASK) | (csr_wdata & MSTATUS_WMASK);
          CSR_MEPC:    r_mepc    <= csr_wdata & ALIGN_MASK;
          CSR_MCAUSE:  r_mcause  <= csr_wdata;
          CSR_MTVAL:   r_mtval   <= csr_wdata;
          default:     ;
        endcase
      end
      if (r_state == SAVE) begin
        r_redirect_pc <= w_target;
      end
    end
  end

  assign irq_en         = r_mstatus[MSTATUS_MIE];
  assign mstatus        = r_mstatus;
  assign mepc           = r_mepc;
  assign mcause         = r_mcause;
  assign mtval          = r_mtval;
  assign redirect_valid = (r_state == REDIRECT);
  assign redirect_pc    = r_redirect_pc;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus a randomized
// run, all checked against a transaction-level model of the CSR rules.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst, boundary, trap_pending, mret, csr_we, redirect_ready;
  logic        irq_en, redirect_valid, busy;
  logic [31:0] trap_cause, pc, tval, mtvec, csr_wdata;
  logic [31:0] mstatus, mepc, mcause, mtval, redirect_pc;
  logic [11:0] csr_addr;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_mie, m_mpie;
  logic [31:0] m_mepc, m_mcause, m_mtval;

  always #5 clk = ~clk;

  trap_sequencer #(
    .RESET_MSTATUS(32'h0000_1800),
    .XLEN(32)
  ) dut (
    .clk(clk), .rst(rst), .boundary(boundary), .trap_pending(trap_pending),
    .trap_cause(trap_cause), .pc(pc), .tval(tval), .mret(mret), .mtvec(mtvec),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .irq_en(irq_en),
    .mstatus(mstatus), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_mstatus();
    return 32'h0000_1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] vec, input logic [31:0] cause);
    if (vec[1:0] == 2'b01 && cause[31]) return (vec & ~32'h3) + ((cause & 32'h7FFF_FFFF) * 32'd4);
    return vec & ~32'h3;
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
  endtask

  task automatic model_csr(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
      12'h341: m_mepc = d & ~32'h3;
      12'h342: m_mcause = d;
      12'h343: m_mtval = d;
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    boundary = 0; trap_pending = 0; mret = 0; csr_we = 0;
    csr_addr = '0; csr_wdata = '0; trap_cause = '0; pc = '0; tval = '0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 0;
    model_csr(a, d);
  endtask

  // One accept cycle in IDLE; trap wins over mret in the model.
  task automatic accept(input bit t, input bit m, input logic [31:0] c,
                        input logic [31:0] p, input logic [31:0] v);
    boundary = 1; trap_pending = t; mret = m; trap_cause = c; pc = p; tval = v;
    tick();
    boundary = 0; trap_pending = 0; mret = 0;
    if (t) begin
      m_mpie = m_mie; m_mie = 0; m_mepc = p & ~32'h3; m_mcause = c; m_mtval = v;
    end else if (m) begin
      m_mie = m_mpie; m_mpie = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1; redirect_ready = 1; mtvec = '0; idle_inputs();
    tick(); tick();
    rst = 0;
    model_reset();
    checks++;
    if ({busy, redirect_valid, redirect_pc, irq_en, mstatus, mepc, mcause, mtval} !==
        {1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_1800, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_state: got busy=%b rv=%b rpc=%h irq=%b mst=%h mepc=%h mcause=%h mtval=%h required 0 0 0 0 00001800 0 0 0",
               busy, redirect_valid, redirect_pc, irq_en, mstatus, mepc, mcause, mtval);
    end
  endtask

  task automatic test_direct_trap();
    mtvec = 32'h0000_0100; redirect_ready = 1;
    csr_write(12'h300, 32'h0000_0008);
    accept(1, 0, 32'h2, 32'h44, 32'hDEAD_BEEF);
    checks++;
    if ({mepc, mcause, mtval, mstatus, irq_en, busy, redirect_valid} !==
        {32'h44, 32'h2, 32'hDEAD_BEEF, 32'h0000_1880, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL direct_csrs: got mepc=%h mcause=%h mtval=%h mst=%h irq=%b busy=%b rv=%b required 44 2 deadbeef 00001880 0 1 0",
               mepc, mcause, mtval, mstatus, irq_en, busy, redirect_valid);
    end
    tick();
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL direct_redirect: got rv=%b rpc=%h required 1 00000100", redirect_valid, redirect_pc);
    end
    tick();
    checks++;
    if ({busy, redirect_valid} !== 2'b00) begin
      failures++;
      $display("FAIL direct_idle: got busy=%b rv=%b required 0 0", busy, redirect_valid);
    end
  endtask

  task automatic test_vectored();
    logic [31:0] causes [2];
    logic [31:0] want   [2];
    causes[0] = 32'h8000_0007; want[0] = 32'h0000_021C;
    causes[1] = 32'h0000_0002; want[1] = 32'h0000_0200;
    redirect_ready = 1;
    for (int unsigned i = 0; i < 2; i++) begin
      mtvec = 32'hFFF0_0000;               // changed before SAVE: only the SAVE-cycle value counts
      accept(1, 0, causes[i], 32'h1000 + 32'(i * 4), 32'h0);
      mtvec = 32'h0000_0201;
      tick();
      checks++;
      if ({redirect_valid, redirect_pc} !== {1'b1, want[i]}) begin
        failures++;
        $display("FAIL vectored_%0d: got rv=%b rpc=%h required 1 %h", i, redirect_valid, redirect_pc, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_mret();
    redirect_ready = 1; mtvec = 32'h0000_0100;
    csr_write(12'h341, 32'h0000_0080);
    csr_write(12'h300, 32'h0000_0080);
    accept(0, 1, 32'h0, 32'h0, 32'h0);
    checks++;
    if ({mstatus, irq_en, mepc} !== {32'h0000_1888, 1'b1, 32'h80}) begin
      failures++;
      $display("FAIL mret_status: got mst=%h irq=%b mepc=%h required 00001888 1 00000080", mstatus, irq_en, mepc);
    end
    tick();
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h80}) begin
      failures++;
      $display("FAIL mret_redirect: got rv=%b rpc=%h required 1 00000080", redirect_valid, redirect_pc);
    end
    tick();
    // Trap and mret together: the trap is taken.
    accept(1, 1, 32'h0000_000B, 32'h0000_003C, 32'h0);
    checks++;
    if ({mepc, mcause, mstatus} !== {32'h3C, 32'hB, 32'h0000_1880}) begin
      failures++;
      $display("FAIL collision_csrs: got mepc=%h mcause=%h mst=%h required 0000003c 0000000b 00001880", mepc, mcause, mstatus);
    end
    tick();
    checks++;
    if (redirect_pc !== 32'h100) begin
      failures++;
      $display("FAIL collision_redirect: got rpc=%h required 00000100", redirect_pc);
    end
    tick();
  endtask

  task automatic test_backpressure();
    mtvec = 32'h0000_0300; redirect_ready = 0;
    accept(1, 0, 32'h5, 32'h208, 32'h77);
    tick();
    for (int unsigned i = 0; i < 5; i++) begin
      boundary = 1; trap_pending = 1; trap_cause = 32'h9; pc = 32'hABC0;   // must be ignored
      checks++;
      if ({redirect_valid, busy, redirect_pc} !== {1'b1, 1'b1, 32'h300}) begin
        failures++;
        $display("FAIL backpressure_hold_%0d: got rv=%b busy=%b rpc=%h required 1 1 00000300", i, redirect_valid, busy, redirect_pc);
      end
      tick();
    end
    boundary = 0; trap_pending = 0; redirect_ready = 1;
    tick();
    checks++;
    if ({busy, redirect_valid, mepc, mcause} !== {1'b0, 1'b0, 32'h208, 32'h5}) begin
      failures++;
      $display("FAIL backpressure_release: got busy=%b rv=%b mepc=%h mcause=%h required 0 0 00000208 00000005",
               busy, redirect_valid, mepc, mcause);
    end
  endtask

  task automatic test_csr_write();
    csr_write(12'h300, 32'hFFFF_FFFF);
    checks++;
    if (mstatus !== 32'h0000_1888) begin
      failures++;
      $display("FAIL csr_mstatus: got %h required 00001888", mstatus);
    end
    csr_write(12'h341, 32'h0000_0123);
    csr_write(12'h342, 32'hC000_0003);
    csr_write(12'h343, 32'h1234_5678);
    csr_write(12'h305, 32'hFFFF_FFFF);
    checks++;
    if ({mepc, mcause, mtval, mstatus} !== {32'h120, 32'hC000_0003, 32'h1234_5678, 32'h0000_1888}) begin
      failures++;
      $display("FAIL csr_fields: got mepc=%h mcause=%h mtval=%h mst=%h required 00000120 c0000003 12345678 00001888",
               mepc, mcause, mtval, mstatus);
    end
    // Write in the accept cycle, in SAVE and in REDIRECT: all dropped.
    redirect_ready = 0; mtvec = 32'h100;
    csr_we = 1; csr_addr = 12'h300; csr_wdata = 32'h0000_0088;
    accept(1, 0, 32'h4, 32'h50, 32'h0);
    csr_addr = 12'h342; csr_wdata = 32'h5555_5555;
    tick();
    csr_addr = 12'h341; csr_wdata = 32'hAAAA_AAAC;
    tick();
    csr_we = 0; redirect_ready = 1;
    tick();
    checks++;
    if ({mstatus, mcause, mepc} !== {32'h0000_1880, 32'h4, 32'h50}) begin
      failures++;
      $display("FAIL csr_dropped: got mst=%h mcause=%h mepc=%h required 00001880 00000004 00000050", mstatus, mcause, mepc);
    end
  endtask

  task automatic test_reset_mid();
    redirect_ready = 0; mtvec = 32'h400;
    accept(1, 0, 32'h6, 32'h90, 32'h33);
    tick();
    rst = 1;
    tick();
    rst = 0; redirect_ready = 1;
    model_reset();
    checks++;
    if ({redirect_valid, busy, redirect_pc, mstatus, mepc, mcause, mtval} !==
        {1'b0, 1'b0, 32'h0, 32'h0000_1800, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid: got rv=%b busy=%b rpc=%h mst=%h mepc=%h mcause=%h mtval=%h required 0 0 0 00001800 0 0 0",
               redirect_valid, busy, redirect_pc, mstatus, mepc, mcause, mtval);
    end
  endtask

  task automatic test_random();
    logic [11:0] addrs [5];
    logic [31:0] tgt, c;
    bit          is_trap;
    int unsigned stall;
    addrs[0] = 12'h300; addrs[1] = 12'h341; addrs[2] = 12'h342; addrs[3] = 12'h343; addrs[4] = 12'h344;
    for (int unsigned it = 0; it < 60; it++) begin
      // Idle cycles: not at a boundary, so CSR writes are honoured.
      for (int unsigned k = 0; k < $urandom_range(0, 2); k++) begin
        boundary = 0; trap_pending = 1'($urandom); mret = 1'($urandom);
        csr_we = 1'($urandom); csr_addr = addrs[$urandom_range(0, 4)]; csr_wdata = $urandom;
        tick();
        if (csr_we) model_csr(csr_addr, csr_wdata);
        csr_we = 0; trap_pending = 0; mret = 0;
        checks++;
        if ({busy, mstatus, mepc, mcause, mtval} !== {1'b0, exp_mstatus(), m_mepc, m_mcause, m_mtval}) begin
          failures++;
          $display("FAIL rand_idle_%0d: got busy=%b mst=%h mepc=%h mcause=%h mtval=%h required 0 %h %h %h %h",
                   it, busy, mstatus, mepc, mcause, mtval, exp_mstatus(), m_mepc, m_mcause, m_mtval);
        end
      end
      is_trap = 1'($urandom);
      c = ($urandom_range(0, 1) == 1) ? $urandom : {1'($urandom), 27'h0, 4'($urandom)};
      mtvec = $urandom;
      redirect_ready = 0;
      accept(is_trap, is_trap ? 1'($urandom) : 1'b1, c, $urandom, $urandom);
      checks++;
      if ({busy, irq_en, mstatus, mepc, mcause, mtval} !== {1'b1, m_mie, exp_mstatus(), m_mepc, m_mcause, m_mtval}) begin
        failures++;
        $display("FAIL rand_accept_%0d: got busy=%b irq=%b mst=%h mepc=%h mcause=%h mtval=%h required 1 %b %h %h %h %h",
                 it, busy, irq_en, mstatus, mepc, mcause, mtval, m_mie, exp_mstatus(), m_mepc, m_mcause, m_mtval);
      end
      // SAVE cycle: fresh mtvec (any mode), junk requests and writes.
      mtvec = $urandom;
      tgt = is_trap ? exp_target(mtvec, m_mcause) : m_mepc;
      boundary = 1'($urandom); trap_pending = 1'($urandom); csr_we = 1'($urandom);
      csr_addr = addrs[$urandom_range(0, 3)]; csr_wdata = $urandom;
      stall = $urandom_range(0, 3);
      tick();
      mtvec = $urandom;
      for (int unsigned s = 0; s <= stall; s++) begin
        redirect_ready = (s == stall);
        checks++;
        if ({redirect_valid, busy, redirect_pc} !== {1'b1, 1'b1, tgt}) begin
          failures++;
          $display("FAIL rand_redirect_%0d_%0d: got rv=%b busy=%b rpc=%h required 1 1 %h", it, s, redirect_valid, busy, redirect_pc, tgt);
        end
        tick();
      end
      idle_inputs();
      checks++;
      if ({busy, redirect_valid, mstatus, mepc, mcause, mtval} !== {1'b0, 1'b0, exp_mstatus(), m_mepc, m_mcause, m_mtval}) begin
        failures++;
        $display("FAIL rand_done_%0d: got busy=%b rv=%b mst=%h mepc=%h mcause=%h mtval=%h required 0 0 %h %h %h %h",
                 it, busy, redirect_valid, mstatus, mepc, mcause, mtval, exp_mstatus(), m_mepc, m_mcause, m_mtval);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct_trap();
    test_vectored();
    test_mret();
    test_backpressure();
    test_csr_write();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
